control_idle_fsm: RTL and testbench

//  Main state machine that drives IDLE_OUT into the recirculation demux. The demux loops probador data

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/control_idle_fsm_if.sv | 37 +++
 rtl/control_idle_fsm_idle_hold_cnt.sv | 23 ++
 rtl/control_idle_fsm.sv | 134 +++++++++++++
 tb/tb_control_idle_fsm.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared state encoding for the idle controller; the recirculation bench and
// the probador decode the `state` output with these constants.
package ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

  function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
    return s <= ST_ERROR;
  endfunction

endpackage

// File: rtl/control_idle_fsm_if.sv
// FIFO status / threshold bundle between the idle controller (slave) and
// whatever drives its inputs and consumes its outputs (master).
interface control_idle_fsm_if
  import ctrl_pkg::*;
#(
  parameter int N_FIFO = 4,
  parameter int UMB_W  = 4
);

  logic                 init;
  logic [UMB_W-1:0]     umbral_alto_in;
  logic [UMB_W-1:0]     umbral_bajo_in;
  logic [N_FIFO-1:0]    fifo_empty;
  logic [N_FIFO-1:0]    fifo_error;

  logic [STATE_W-1:0]   state;
  logic                 IDLE_OUT;
  logic                 active_out;
  logic                 error_out;
  logic [N_FIFO-1:0]    error_fifo;
  logic                 cfg_invalid;
  logic [UMB_W-1:0]     umbral_alto_out;
  logic [UMB_W-1:0]     umbral_bajo_out;

  modport master (
    output init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_error,
    input  state, IDLE_OUT, active_out, error_out, error_fifo, cfg_invalid,
           umbral_alto_out, umbral_bajo_out
  );

  modport slave (
    input  init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_error,
    output state, IDLE_OUT, active_out, error_out, error_fifo, cfg_invalid,
           umbral_alto_out, umbral_bajo_out
  );

endinterface

// File: rtl/control_idle_fsm_idle_hold_cnt.sv
// Saturating up-counter with synchronous clear; counts consecutive all-empty
// cycles spent in ACTIVE.
module control_idle_fsm_idle_hold_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/control_idle_fsm.sv
// Idle controller: drives IDLE_OUT to the recirculation demux once every FIFO
// has stayed empty long enough, latches FIFO thresholds in INIT, traps errors.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  RESET  | post-reset, all outputs cleared; moves to INIT next edge
//  INIT   | thresholds latched when valid; waits for init=0 and a valid config
//  IDLE   | all FIFOs drained, IDLE_OUT=1 forwards data to stage 2
//  ACTIVE | traffic present; counts all-empty cycles toward IDLE
//  ERROR  | a FIFO flagged an error; sticky until reset
module control_idle_fsm
  import ctrl_pkg::*;
#(
  parameter int N_FIFO    = 4,
  parameter int UMB_W     = 4,
  parameter int IDLE_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  control_idle_fsm_if.slave   bus
);

  localparam int               CNT_W     = $clog2(IDLE_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(IDLE_HOLD - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt;
  logic               cnt_inc;

  logic               all_empty;
  logic               any_error;
  logic               cfg_ok;
  logic               hold_done;

  logic               idle_q, idle_d;
  logic               active_q, active_d;
  logic               error_q, error_d;
  logic               cfg_inv_q, cfg_inv_d;
  logic [N_FIFO-1:0]  err_fifo_q, err_fifo_d;
  logic [UMB_W-1:0]   alto_q, alto_d;
  logic [UMB_W-1:0]   bajo_q, bajo_d;

  assign all_empty = &bus.fifo_empty;
  assign any_error = |bus.fifo_error;
  assign cfg_ok    = bus.umbral_bajo_in < bus.umbral_alto_in;
  assign hold_done = hold_cnt == HOLD_LAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      idle_q     <= 1'b0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
      cfg_inv_q  <= 1'b0;
      err_fifo_q <= '0;
      alto_q     <= '0;
      bajo_q     <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      active_q   <= active_d;
      error_q    <= error_d;
      cfg_inv_q  <= cfg_inv_d;
      err_fifo_q <= err_fifo_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (any_error)                  state_d = ST_ERROR;
        else if (bus.init || !cfg_ok)   state_d = ST_INIT;
        else                            state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_error)                  state_d = ST_ERROR;
        else if (bus.init)              state_d = ST_INIT;
        else if (!all_empty)            state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // a non-empty lane in the completing cycle keeps us ACTIVE
        if (any_error)                  state_d = ST_ERROR;
        else if (bus.init)              state_d = ST_INIT;
        else if (all_empty && hold_done) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    idle_d     = state_d == ST_IDLE;
    active_d   = state_d == ST_ACTIVE;
    error_d    = state_d == ST_ERROR;
    cfg_inv_d  = (state_d == ST_INIT) && !cfg_ok;
    err_fifo_d = err_fifo_q;
    alto_d     = alto_q;
    bajo_d     = bajo_q;
    if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
      err_fifo_d = bus.fifo_error;
    end
    if ((state_q == ST_INIT) && cfg_ok) begin
      alto_d = bus.umbral_alto_in;
      bajo_d = bus.umbral_bajo_in;
    end
  end

  assign cnt_inc = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && all_empty;

  control_idle_fsm_idle_hold_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!cnt_inc),
    .inc   (cnt_inc),
    .count (hold_cnt)
  );

  assign bus.state           = state_q;
  assign bus.IDLE_OUT        = idle_q;
  assign bus.active_out      = active_q;
  assign bus.error_out       = error_q;
  assign bus.error_fifo      = err_fifo_q;
  assign bus.cfg_invalid     = cfg_inv_q;
  assign bus.umbral_alto_out = alto_q;
  assign bus.umbral_bajo_out = bajo_q;

endmodule

// File: tb/tb_control_idle_fsm.sv
// Bench for control_idle_fsm: directed scenarios then random traffic, checked
// every cycle against a cycle-level model, for IDLE_HOLD=4 and IDLE_HOLD=1.
module tb_control_idle_fsm;

  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  typedef struct {
    int         st;
    int         streak;
    logic [3:0] alto;
    logic [3:0] bajo;
    logic [3:0] efifo;
    bit         cfg_inv;
  } mdl_t;

  logic       clk;
  logic       reset;
  logic       ini;
  logic [3:0] alto, bajo, emp, err;

  int   n_total = 0;
  int   n_bad   = 0;
  mdl_t ma, mb;

  control_idle_fsm_if #(.N_FIFO(4), .UMB_W(4)) ifa ();
  control_idle_fsm_if #(.N_FIFO(4), .UMB_W(4)) ifb ();

  assign ifa.init = ini;  assign ifa.umbral_alto_in = alto;  assign ifa.umbral_bajo_in = bajo;
  assign ifa.fifo_empty = emp;  assign ifa.fifo_error = err;
  assign ifb.init = ini;  assign ifb.umbral_alto_in = alto;  assign ifb.umbral_bajo_in = bajo;
  assign ifb.fifo_empty = emp;  assign ifb.fifo_error = err;

  control_idle_fsm #(.N_FIFO(4), .UMB_W(4), .IDLE_HOLD(4)) dut_a (
    .clk (clk), .reset (reset), .bus (ifa)
  );
  control_idle_fsm #(.N_FIFO(4), .UMB_W(4), .IDLE_HOLD(1)) dut_b (
    .clk (clk), .reset (reset), .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of behaviour; hold = cycles of clean emptiness needed to go idle.
  function automatic mdl_t step(input mdl_t m, input bit rst, input bit in_init,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] e, input logic [3:0] er, input int hold);
    mdl_t n = m;
    bit ok = b < a;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (m.st == S_INIT && ok) begin
      n.alto = a;
      n.bajo = b;
    end
    if (m.st > S_ERROR)                       n.st = S_RESET;
    else if (m.st != S_RESET && er != 4'h0) begin
      if (m.st != S_ERROR) n.efifo = er;
      n.st = S_ERROR;
    end
    else if (m.st == S_ERROR)                 n.st = S_ERROR;
    else if (m.st == S_RESET)                 n.st = S_INIT;
    else if (in_init)                         n.st = S_INIT;
    else if (m.st == S_INIT)                  n.st = ok ? S_IDLE : S_INIT;
    else if (m.st == S_IDLE)                  n.st = (e == 4'hF) ? S_IDLE : S_ACTIVE;
    else begin
      if (e == 4'hF) begin
        n.streak = m.streak + 1;
        if (n.streak >= hold) n.st = S_IDLE;
      end else begin
        n.streak = 0;
      end
    end
    if (n.st != S_ACTIVE) n.streak = 0;
    n.cfg_inv = (n.st == S_INIT) && !ok;
    return n;
  endfunction

  task automatic cmp_all(input string p, input mdl_t m, input logic [2:0] st,
                         input logic io, input logic ao, input logic eo,
                         input logic [3:0] ef, input logic ci,
                         input logic [3:0] ua, input logic [3:0] ub);
    chk({p, "state"},    32'(st), 32'(m.st));
    chk({p, "idle_out"}, 32'(io), 32'(m.st == S_IDLE));
    chk({p, "active"},   32'(ao), 32'(m.st == S_ACTIVE));
    chk({p, "error"},    32'(eo), 32'(m.st == S_ERROR));
    chk({p, "efifo"},    32'(ef), 32'(m.efifo));
    chk({p, "cfg_inv"},  32'(ci), 32'(m.cfg_inv));
    chk({p, "alto"},     32'(ua), 32'(m.alto));
    chk({p, "bajo"},     32'(ub), 32'(m.bajo));
  endtask

  task automatic tick();
    @(posedge clk);
    ma = step(ma, reset, ini, alto, bajo, emp, err, 4);
    mb = step(mb, reset, ini, alto, bajo, emp, err, 1);
    #1;
    cmp_all("a_", ma, ifa.state, ifa.IDLE_OUT, ifa.active_out, ifa.error_out,
            ifa.error_fifo, ifa.cfg_invalid, ifa.umbral_alto_out, ifa.umbral_bajo_out);
    cmp_all("b_", mb, ifb.state, ifb.IDLE_OUT, ifb.active_out, ifb.error_out,
            ifb.error_fifo, ifb.cfg_invalid, ifb.umbral_alto_out, ifb.umbral_bajo_out);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    reset = 1'b1; ini = 1'b0; alto = 4'd0; bajo = 4'd0; emp = 4'hF; err = 4'h0;

    // reset, INIT, then IDLE with thresholds 8/2
    tick(); tick();
    chk("t1_rst_state", 32'(ifa.state), S_RESET);
    reset = 1'b0; ini = 1'b1; alto = 4'd8; bajo = 4'd2;
    tick();
    chk("t1_init_state", 32'(ifa.state), S_INIT);
    chk("t1_init_alto", 32'(ifa.umbral_alto_out), 32'd0);
    ini = 1'b0;
    tick();
    chk("t1_idle", 32'(ifa.IDLE_OUT), 32'd1);
    chk("t1_alto", 32'(ifa.umbral_alto_out), 32'd8);
    chk("t1_bajo", 32'(ifa.umbral_bajo_out), 32'd2);

    // brief traffic, back to IDLE after 4 clean cycles (1 for dut_b)
    emp = 4'b1101;
    tick();
    chk("t2_active", 32'(ifa.active_out), 32'd1);
    emp = 4'hF;
    tick();
    chk("t2_b_idle", 32'(ifb.IDLE_OUT), 32'd1);
    tick(); tick();
    chk("t2_still_active", 32'(ifa.state), S_ACTIVE);
    tick();
    chk("t2_idle", 32'(ifa.state), S_IDLE);

    // hold interrupted after 3 clean cycles restarts the count
    emp = 4'b1101; tick();
    emp = 4'hF; tick(); tick(); tick();
    emp = 4'b0111; tick();
    emp = 4'hF; tick(); tick(); tick();
    chk("t3_restart", 32'(ifa.state), S_ACTIVE);
    tick();
    chk("t3_idle", 32'(ifa.state), S_IDLE);

    // error during ACTIVE is sticky, ignores init, cleared by reset
    emp = 4'b1101; tick();
    emp = 4'hF; tick();
    err = 4'b0100; tick();
    chk("t4_err_out", 32'(ifa.error_out), 32'd1);
    chk("t4_efifo", 32'(ifa.error_fifo), 32'h4);
    err = 4'h0; ini = 1'b1; tick(); tick();
    chk("t4_sticky", 32'(ifa.state), S_ERROR);
    reset = 1'b1; tick();
    chk("t4_rst", 32'(ifa.state), S_RESET);

    // invalid threshold pair holds INIT and keeps old thresholds
    reset = 1'b0; ini = 1'b1; alto = 4'd8; bajo = 4'd2; tick(); tick();
    alto = 4'd3; bajo = 4'd5; tick();
    ini = 1'b0; tick();
    chk("t5_stay", 32'(ifa.state), S_INIT);
    chk("t5_cfg_inv", 32'(ifa.cfg_invalid), 32'd1);
    chk("t5_keep_alto", 32'(ifa.umbral_alto_out), 32'd8);
    bajo = 4'd1; tick();
    chk("t5_idle", 32'(ifa.state), S_IDLE);
    chk("t5_cfg_ok", 32'(ifa.cfg_invalid), 32'd0);
    chk("t5_new_bajo", 32'(ifa.umbral_bajo_out), 32'd1);

    // reset and error together mid-hold: reset wins
    emp = 4'b1101; tick();
    emp = 4'hF; tick(); tick();
    reset = 1'b1; err = 4'b0010; tick();
    chk("t6_state", 32'(ifa.state), S_RESET);
    chk("t6_err_out", 32'(ifa.error_out), 32'd0);
    chk("t6_efifo", 32'(ifa.error_fifo), 32'd0);
    reset = 1'b0; err = 4'h0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      ini   = ($urandom_range(0, 39) == 0);
      err   = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      emp   = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        alto = 4'($urandom);
        bajo = 4'($urandom);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
